// File: rtl/rhd_spi_master.sv
// SPI master that streams CONVERT(k) commands to an RHD amplifier and returns DDR-sampled results.
// Define RHD_SPI_MASTER_FIFO_EN to place a 4-entry result FIFO in front of the handshake.
module rhd_spi_master #(
    parameter int unsigned HALF_SCLK = 4,
    parameter int unsigned CS_GAP    = 8,
    parameter int unsigned NUM_CH    = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        MISO,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] data_a,
    output logic [15:0] data_b,
    output logic [5:0]  data_ch,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        overflow
);

    localparam logic [7:0] HalfLast = 8'(HALF_SCLK - 1);
    localparam logic [7:0] GapLast  = 8'(CS_GAP - 1);
    localparam logic [5:0] ChLast   = 6'(NUM_CH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] mosi_sr_q, mosi_sr_d;
    logic [14:0] sr_a_q, sr_a_d;
    logic [15:0] sr_b_q, sr_b_d;
    logic [5:0]  k_q, k_d;
    logic [1:0]  discard_q, discard_d;

    logic        push;
    logic [5:0]  res_ch;
    logic [37:0] push_data;

    function automatic logic [15:0] convert_cmd(input logic [5:0] k);
        return {2'b00, k, 8'h00};
    endfunction

    // The device pipeline is two frames deep, so this frame returns channel k-2.
    always_comb begin
        res_ch = (k_q >= 6'd2) ? k_q - 6'd2 : 6'(32'(k_q) + NUM_CH - 32'd2);
    end

    assign push_data = {res_ch, sr_a_q, MISO, sr_b_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        sclk_d    = sclk_q;
        bit_d     = bit_q;
        mosi_sr_d = mosi_sr_q;
        sr_a_d    = sr_a_q;
        sr_b_d    = sr_b_q;
        k_d       = k_q;
        discard_d = discard_q;
        push      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (enable) begin
                    state_d   = StSetup;
                    mosi_sr_d = convert_cmd(k_q);
                    discard_d = 2'd2;
                end
            end
            StSetup: begin
                if (cnt_q == HalfLast) begin
                    state_d = StShift;
                    cnt_d   = 8'd0;
                    sclk_d  = 1'b0;
                    bit_d   = 4'd0;
                end
            end
            StShift: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Low halves after a rising edge carry data_a; period 0 has none.
                        if (bit_q != 4'd0) sr_a_d = {sr_a_q[13:0], MISO};
                    end else begin
                        sclk_d = 1'b0;
                        sr_b_d = {sr_b_q[14:0], MISO};
                        if (bit_q == 4'd15) begin
                            state_d = StHold;
                        end else begin
                            bit_d     = bit_q + 4'd1;
                            mosi_sr_d = {mosi_sr_q[14:0], 1'b0};
                        end
                    end
                end
            end
            StHold: begin
                if (cnt_q == HalfLast) begin
                    state_d = StGap;
                    cnt_d   = 8'd0;
                    k_d     = (k_q == ChLast) ? 6'd0 : k_q + 6'd1;
                    if (discard_q != 2'd0) discard_d = discard_q - 2'd1;
                    else push = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = 8'd0;
                    if (enable) begin
                        state_d   = StSetup;
                        mosi_sr_d = convert_cmd(k_q);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            sclk_q    <= 1'b0;
            bit_q     <= 4'd0;
            mosi_sr_q <= 16'd0;
            sr_a_q    <= 15'd0;
            sr_b_q    <= 16'd0;
            k_q       <= 6'd0;
            discard_q <= 2'd2;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sclk_q    <= sclk_d;
            bit_q     <= bit_d;
            mosi_sr_q <= mosi_sr_d;
            sr_a_q    <= sr_a_d;
            sr_b_q    <= sr_b_d;
            k_q       <= k_d;
            discard_q <= discard_d;
        end
    end

    assign CS   = (state_q == StIdle) || (state_q == StGap);
    assign SCLK = (state_q == StShift) && sclk_q;
    assign MOSI = mosi_sr_q[15];

`ifdef RHD_SPI_MASTER_FIFO_EN
    logic [37:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        ovf_q;
    logic        do_pop, do_push;

    assign do_pop  = (count_q != 3'd0) && data_ready;
    assign do_push = push && ((count_q != 3'd4) || do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(do_push) - 3'(do_pop);
            if (push && !do_push) ovf_q <= 1'b1;
        end
    end

    assign {data_ch, data_a, data_b} = fifo_q[rd_ptr_q];
    assign data_valid = (count_q != 3'd0);
    assign overflow   = ovf_q;
`else
    logic [37:0] out_q;
    logic        out_valid_q;
    logic        ovf_q;

    // A result arriving on a transfer clk replaces the departing one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (push && (!out_valid_q || data_ready)) begin
                out_q       <= push_data;
                out_valid_q <= 1'b1;
            end else if (data_ready) begin
                out_valid_q <= 1'b0;
            end
            if (push && out_valid_q && !data_ready) ovf_q <= 1'b1;
        end
    end

    assign {data_ch, data_a, data_b} = out_q;
    assign data_valid = out_valid_q;
    assign overflow   = ovf_q;
`endif

endmodule
